// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver.
// Brings the asynchronous serial line into the clk domain and finds the start-bit
// falling edge. Each bit is sampled once at mid-period. A correctly framed byte is
// presented on uart_data together with a one-cycle uart_done strobe. A low stop bit
// produces a one-cycle frame_err strobe instead, and uart_data is left untouched.
module uart_recv #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned UART_BPS = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       frame_err,
    output logic       rx_busy
);

    // Cycles per bit; the design needs at least 4 so that the midpoint and the
    // wrap point fall in different cycles.
    localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int unsigned CNT_W   = $clog2(BPS_CNT);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_CNT / 2);

    localparam logic [3:0] LAST_DATA_BIT = 4'd8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic             rxd_s1_q, rxd_s1_d;
    logic             rxd_s2_q, rxd_s2_d;
    logic             rxd_s3_q, rxd_s3_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;

    logic             start_fall;
    logic             cnt_wrap;
    logic             sample_pt;
    logic [2:0]       bit_idx;

    // Synchroniser chain; the third stage only serves edge detection.
    always_comb begin
        rxd_s1_d = uart_rxd;
        rxd_s2_d = rxd_s1_q;
        rxd_s3_d = rxd_s2_q;
    end

    // Timing events derived from the synchronised line and the bit counters.
    always_comb begin
        start_fall = rxd_s3_q & ~rxd_s2_q;
        cnt_wrap   = (clk_cnt_q == CNT_MAX);
        sample_pt  = (clk_cnt_q == CNT_MID);
        bit_idx    = 3'(bit_cnt_q - 4'd1);
    end

    // Frame FSM: bit timing, data capture and the output strobes.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        // Counters run in every active state and are held at zero in IDLE.
        if (state_q != IDLE) begin
            if (cnt_wrap) begin
                clk_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                bit_cnt_d = bit_cnt_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample_pt && rxd_s2_q) begin
                    // Line went high again before mid-bit: a glitch, not a start bit.
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end else if (cnt_wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_pt) begin
                    shift_d[bit_idx] = rxd_s2_q;
                end
                if (cnt_wrap && (bit_cnt_q == LAST_DATA_BIT)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit of slack before the next start edge.
                if (sample_pt) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    if (rxd_s2_q) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q  <= 1'b0;
            rxd_s2_q  <= 1'b0;
            rxd_s3_q  <= 1'b0;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rxd_s1_q  <= rxd_s1_d;
            rxd_s2_q  <= rxd_s2_d;
            rxd_s3_q  <= rxd_s3_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    // Output mapping.
    always_comb begin
        uart_data = data_q;
        uart_done = done_q;
        frame_err = ferr_q;
        rx_busy   = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed bench for uart_recv with BPS_CNT = 10.
module tb_uart_recv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b0;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    logic       rx_busy;

    int unsigned total = 0;
    int unsigned bad = 0;

    uart_recv #(
        .CLK_FREQ(1000),
        .UART_BPS(100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .uart_data(uart_data),
        .uart_done(uart_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge.
    int unsigned done_cnt = 0, ferr_cnt = 0, both_cnt = 0, multi_cnt = 0;
    int unsigned last_done_cyc = 0, last_ferr_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
    logic [7:0]  last_done_data = 8'h00;
    logic        prev_done = 1'b0, prev_ferr = 1'b0, prev_busy = 1'b0;
    int unsigned done_cyc_q[$];
    logic [7:0]  done_data_q[$];

    always @(negedge clk) begin
        if (uart_done === 1'b1) begin
            done_cnt       <= done_cnt + 1;
            last_done_cyc  <= cyc;
            last_done_data <= uart_data;
            done_cyc_q.push_back(cyc);
            done_data_q.push_back(uart_data);
        end
        if (frame_err === 1'b1) begin
            ferr_cnt      <= ferr_cnt + 1;
            last_ferr_cyc <= cyc;
        end
        if (uart_done === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
        if ((uart_done === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_ferr))
            multi_cnt <= multi_cnt + 1;
        if (rx_busy === 1'b1 && !prev_busy) busy_rise_cyc <= cyc;
        if (rx_busy === 1'b0 && prev_busy) busy_fall_cyc <= cyc;
        prev_done <= (uart_done === 1'b1);
        prev_ferr <= (frame_err === 1'b1);
        prev_busy <= (rx_busy === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns aligned the same way.
    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame with exact 10-cycle bits; t0 is the cycle the start bit began.
    task automatic send(input logic [7:0] d, input logic stop, output int unsigned t0);
        logic [9:0] fb;
        fb = {stop, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fb[i];
            repeat (10) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int unsigned t0, n_done, n_ferr;
        logic [9:0]  fb;

        // Reset with the line low.
        uart_rxd = 1'b0;
        rst_n    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_data", 32'(uart_data), 32'h00);
        check("rst_done", 32'(uart_done), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        repeat (200) @(posedge clk);
        #1;
        check("rst_low_no_done", done_cnt, 0);
        check("rst_low_no_busy", 32'(rx_busy), 32'd0);
        idle(10);
        send(8'h55, 1'b1, t0);
        check("rst_frame_count", done_cnt, 1);
        check("rst_frame_data", 32'(last_done_data), 32'h55);

        // Single byte with exact timing.
        idle(10);
        n_done = done_cnt;
        send(8'hA5, 1'b1, t0);
        check("single_count", done_cnt - n_done, 1);
        check("single_done_cycle", last_done_cyc - t0, 99);
        check("single_data", 32'(last_done_data), 32'hA5);
        check("single_busy_rise", busy_rise_cyc - t0, 3);
        check("single_busy_fall", busy_fall_cyc - t0, 99);
        check("single_busy_now", 32'(rx_busy), 32'd0);

        // Back-to-back frames, no idle gap.
        idle(10);
        n_ferr = ferr_cnt;
        done_cyc_q.delete();
        done_data_q.delete();
        send(8'h00, 1'b1, t0);
        send(8'hFF, 1'b1, t0);
        send(8'h3C, 1'b1, t0);
        idle(5);
        check("b2b_count", done_cyc_q.size(), 3);
        if (done_cyc_q.size() == 3) begin
            check("b2b_data0", 32'(done_data_q[0]), 32'h00);
            check("b2b_data1", 32'(done_data_q[1]), 32'hFF);
            check("b2b_data2", 32'(done_data_q[2]), 32'h3C);
            check("b2b_gap01", done_cyc_q[1] - done_cyc_q[0], 100);
            check("b2b_gap12", done_cyc_q[2] - done_cyc_q[1], 100);
        end
        check("b2b_no_ferr", ferr_cnt - n_ferr, 0);

        // Glitch rejection: 3-cycle low pulse.
        idle(10);
        n_done = done_cnt;
        n_ferr = ferr_cnt;
        t0 = cyc;
        uart_rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(30);
        check("glitch_busy_rise", busy_rise_cyc - t0, 3);
        check("glitch_busy_fall", busy_fall_cyc - t0, 9);
        check("glitch_no_done", done_cnt - n_done, 0);
        check("glitch_no_ferr", ferr_cnt - n_ferr, 0);
        send(8'h81, 1'b1, t0);
        check("glitch_next_count", done_cnt - n_done, 1);
        check("glitch_next_data", 32'(last_done_data), 32'h81);

        // Framing error: stop bit low.
        idle(10);
        n_done = done_cnt;
        n_ferr = ferr_cnt;
        send(8'h12, 1'b0, t0);
        check("ferr_count", ferr_cnt - n_ferr, 1);
        check("ferr_cycle", last_ferr_cyc - t0, 99);
        check("ferr_no_done", done_cnt - n_done, 0);
        check("ferr_data_kept", 32'(uart_data), 32'h81);
        idle(20);
        send(8'h34, 1'b1, t0);
        check("ferr_next_count", done_cnt - n_done, 1);
        check("ferr_next_data", 32'(last_done_data), 32'h34);
        check("ferr_next_out", 32'(uart_data), 32'h34);

        // Reset in the middle of a frame.
        idle(10);
        n_done = done_cnt;
        n_ferr = ferr_cnt;
        fb = {1'b1, 8'h6B, 1'b0};
        for (int i = 0; i < 5; i++) begin
            uart_rxd = fb[i];
            repeat (10) @(posedge clk);
            #1;
        end
        uart_rxd = fb[5];
        repeat (5) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(uart_data), 32'h00);
        check("midrst_done", 32'(uart_done), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        check("midrst_busy", 32'(rx_busy), 32'd0);
        uart_rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        check("midrst_no_pulse", (done_cnt - n_done) + (ferr_cnt - n_ferr), 0);
        send(8'h6B, 1'b1, t0);
        check("midrst_next_count", done_cnt - n_done, 1);
        check("midrst_next_data", 32'(last_done_data), 32'h6B);

        idle(5);
        check("never_both", both_cnt, 0);
        check("never_multi", multi_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_recv.md
# uart_recv

UART receiver for 8N1 frames: it synchronises the asynchronous `uart_rxd` line, detects the start bit and samples each bit at mid-period. It delivers the received byte on `uart_data` with a one-cycle `uart_done` strobe. It sits directly upstream of the UART transmit stage, which consumes `uart_data` and `uart_done` unchanged.

## Interface
- `CLK_FREQ`, default 50000000: clk frequency in Hz.
- `UART_BPS`, default 9600: baud rate.
- `BPS_CNT` (localparam): CLK_FREQ/UART_BPS, integer division, cycles per bit (5208 at defaults). Required to be ≥ 4.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `uart_rxd`  in  1  serial input, asynchronous to clk, idle high.
- `uart_data`  out  8  last correctly framed byte, LSB = first data bit received.
- `uart_done`  out  1  one-cycle pulse when `uart_data` has just been updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit sampled low.
- `rx_busy`  out  1  high while a frame is being received (any state except IDLE).

## Operation
- Input synchroniser: two flops, rxd_s1 then rxd_s2, followed by a third flop rxd_s3 for edge detection. All three reset to 0, so no start is recognised until the line has been seen high after reset.
- Start detect: `start_fall` = rxd_s3 & ~rxd_s2. It is acted on only in IDLE and ignored in every other state.
- Counters:
  - clk_cnt, width clog2(BPS_CNT): counts 0..BPS_CNT-1 and wraps.
  - bit_cnt, 4 bits: 0 = start bit, 1..8 = data bits, 9 = stop bit. It increments when clk_cnt wraps.
  - Both counters are held at 0 in IDLE.
- Sample point: the cycle in which clk_cnt == BPS_CNT/2 (integer division). The value sampled is rxd_s2.
- FSM states:
  - IDLE: on `start_fall`, go to START; clk_cnt and bit_cnt are 0 in the next cycle.
  - START (bit_cnt 0): at the sample point, if rxd_s2 = 1 it is a glitch; return to IDLE with no output pulse. Otherwise continue; when clk_cnt wraps, go to DATA.
  - DATA (bit_cnt 1..8): at the sample point, shift rxd_s2 into shift register bit [bit_cnt-1], LSB first. After bit 8 wraps, go to STOP.
  - STOP (bit_cnt 9): at the sample point, go to IDLE.
    - If rxd_s2 = 1: load shift register into `uart_data` and pulse `uart_done`.
    - If rxd_s2 = 0: pulse `frame_err`; `uart_data` is unchanged.
- Returning to IDLE at the stop-bit midpoint gives half a bit of slack, so back-to-back frames with a single stop bit are received without loss.
- Reset (asserted at any time, including mid-frame):
  - FSM goes to IDLE; counters and shift register go to 0.
  - `uart_data` = 8'h00, `uart_done` = 0, `frame_err` = 0, `rx_busy` = 0.
  - A partial frame is discarded with no pulse.

## Timing
- Let E be the cycle in which `start_fall` is high in IDLE. The falling edge on the pin is seen at most 3 cycles earlier (synchroniser latency).
- In cycle E+1+k: clk_cnt = k mod BPS_CNT and bit_cnt = k div BPS_CNT.
- Stop sample is at k = 9·BPS_CNT + BPS_CNT/2.
- `uart_done` or `frame_err` is high for exactly cycle E+2+9·BPS_CNT+BPS_CNT/2; `uart_data` is valid from that same cycle. At defaults this is E+49478.
- `rx_busy` is high from E+1 through the stop-sample cycle inclusive.
- `uart_done` and `frame_err` are never high in the same cycle. Neither is ever high for more than one cycle.
- `uart_data` is stable between `uart_done` pulses. There is no handshake: the downstream stage must capture on the pulse.
- Tolerated baud mismatch is about ±4% (mid-bit sampling, no resync within a frame).

## Test plan
Run all scenarios with CLK_FREQ=1000 and UART_BPS=100 (BPS_CNT=10). Drive frames on `uart_rxd` with exact 10-cycle bits.

- **Reset:** hold rst_n low with `uart_rxd` low, then release. All outputs must be 0, with no `uart_done` for 200 cycles while the line stays low. Then drive the line high followed by frame 0x55: one `uart_done` pulse must occur, with `uart_data` = 0x55.
- **Single byte:** send 0xA5. `uart_done` must be high for exactly one cycle at E+2+95 = E+97, with `uart_data` = 0xA5. `rx_busy` must fall after the stop sample.
- **Back-to-back:** send 0x00, 0xFF and 0x3C with one stop bit and no idle gap. This must give three `uart_done` pulses 100 cycles apart, with data 0x00, 0xFF, 0x3C and no `frame_err`.
- **Glitch rejection:** drive a 3-cycle low pulse on the idle line. `rx_busy` must go high and then return low after the start sample, with no `uart_done` and no `frame_err`. A following frame 0x81 must then be received correctly.
- **Framing error:** send 0x12 with the stop bit held low. `frame_err` must pulse once, with no `uart_done`, and `uart_data` must keep its previous value. After the line returns high, frame 0x34 must give `uart_done` with `uart_data` = 0x34.
- **Reset mid-frame:** assert rst_n during data bit 4 of frame 0x6B. Outputs must return to 0 immediately, with no pulse. After release and an idle-high period, frame 0x6B must be received correctly.
